// File: rtl/uart_rx_fifo_axils.sv
// UART receiver feeding an RX FIFO, exposed through an AXI4-Lite register slave.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_fifo_axils #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CLK_FREQ           = 100_000_000,
  parameter int DATA_WIDTH         = 8,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            UART_RX,
  output logic                            IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [31:0] DIV_RST = 32'(CLK_FREQ / 9600);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_DIV  = C_S_AXI_ADDR_WIDTH'('h0);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_STAT = C_S_AXI_ADDR_WIDTH'('h4);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_RXD  = C_S_AXI_ADDR_WIDTH'('h8);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_LVL  = C_S_AXI_ADDR_WIDTH'('hC);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;
`endif

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB};

  // Control / status registers
  logic [31:0] div_q;
  logic        intr_en_q, ovr_q, fr_q, irq_q;
  logic [7:0]  thr_q;
  logic        par_en, par_odd, pe;
`ifdef UART_RX_PARITY_EN
  logic        par_en_q, par_odd_q, pe_q, pe_set;
  assign par_en  = par_en_q;
  assign par_odd = par_odd_q;
  assign pe      = pe_q;
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
  assign pe      = 1'b0;
`endif

  // FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          empty, full, rx_push, push_ok, pop, ovr_set, fr_set;
  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign push_ok = rx_push && (!full || pop);
  assign ovr_set = rx_push && !push_ok;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop);
    end
  end

  // ---------------- RX serial path ----------------
  logic [2:0] rx_sync_q;
  logic       rx, fall;
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) rx_sync_q <= '0;
    else              rx_sync_q <= {rx_sync_q[1:0], UART_RX};
  end
  // Resetting the chain low means a line held low across reset cannot look like a start edge.
  assign rx   = rx_sync_q[1];
  assign fall = rx_sync_q[2] && !rx;

  rx_state_e rx_state_q, rx_state_d;
  logic [31:0] cnt_q, cnt_d, divact_q, divact_d, tgt;
  logic [3:0]  bitn_q, bitn_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic        tick;
`ifdef UART_RX_PARITY_EN
  logic        parfail_q, parfail_d;
`endif

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rx_state_q <= S_IDLE;
      cnt_q      <= '0;
      divact_q   <= DIV_RST;
      bitn_q     <= '0;
      shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
      parfail_q  <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      divact_q   <= divact_d;
      bitn_q     <= bitn_d;
      shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
      parfail_q  <= parfail_d;
`endif
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    divact_d   = divact_q;
    bitn_d     = bitn_q;
    shift_d    = shift_q;
    rx_push    = 1'b0;
    fr_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parfail_d  = parfail_q;
    pe_set     = 1'b0;
`endif
    tgt   = (rx_state_q == S_START) ? (divact_q >> 1) - 32'd1 : divact_q - 32'd1;
    tick  = (cnt_q == tgt);
    cnt_d = tick ? '0 : cnt_q + 32'd1;
    case (rx_state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          rx_state_d = S_START;
          divact_d   = div_q;
`ifdef UART_RX_PARITY_EN
          parfail_d  = 1'b0;
`endif
        end
      end
      S_START: if (tick) begin
        rx_state_d = rx ? S_IDLE : S_DATA;
        bitn_d     = '0;
      end
      S_DATA: if (tick) begin
        shift_d = {rx, shift_q[DATA_WIDTH-1:1]};
        bitn_d  = bitn_q + 4'd1;
        if (bitn_q == 4'(DATA_WIDTH - 1))
          rx_state_d = S_STOP;
`ifdef UART_RX_PARITY_EN
        if (bitn_q == 4'(DATA_WIDTH - 1) && par_en)
          rx_state_d = S_PARITY;
      end
      S_PARITY: if (tick) begin
        parfail_d  = ((^{shift_q, rx}) != par_odd);
        rx_state_d = S_STOP;
`endif
      end
      S_STOP: if (tick) begin
        rx_state_d = S_IDLE;
        if (!rx) fr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
        else if (parfail_q) pe_set = 1'b1;
`endif
        else rx_push = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  // ---------------- AXI write channel ----------------
  w_state_e w_state_q, w_state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, wr_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, wr_addr;
  logic [31:0] wdata_q, wdata_d, wr_data, w1c;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    w_state_d     = w_state_q;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wr_en         = 1'b0;
    S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_held_q;
    S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_held_q;
    wr_addr       = aw_held_q ? awaddr_q : S_AXI_AWADDR;
    wr_data       = w_held_q ? wdata_q : S_AXI_WDATA;
    case (w_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
          aw_held_d = 1'b1;
          awaddr_d  = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
        end
        if (aw_held_d && w_held_d) begin
          wr_en     = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      default: if (S_AXI_BREADY) w_state_d = W_IDLE;
    endcase
  end
  assign S_AXI_BVALID = (w_state_q == W_RESP);
  assign S_AXI_BRESP  = '0;
  assign w1c = (wr_en && wr_addr == A_STAT) ? wr_data : '0;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      div_q     <= DIV_RST;
      intr_en_q <= 1'b0;
      thr_q     <= '0;
      ovr_q     <= 1'b0;
      fr_q      <= 1'b0;
      irq_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      if (wr_en && wr_addr == A_DIV)
        div_q <= (wr_data < 32'd4) ? 32'd4 : wr_data;
      if (wr_en && wr_addr == A_STAT) begin
        intr_en_q <= wr_data[8];
        thr_q     <= wr_data[23:16];
`ifdef UART_RX_PARITY_EN
        par_en_q  <= wr_data[9];
        par_odd_q <= wr_data[10];
`endif
      end
      // Set terms are OR'd after the clear so a same-cycle event is never lost.
      ovr_q <= (ovr_q && !w1c[1]) || ovr_set;
      fr_q  <= (fr_q  && !w1c[2]) || fr_set;
`ifdef UART_RX_PARITY_EN
      pe_q  <= (pe_q  && !w1c[3]) || pe_set;
`endif
      irq_q <= intr_en_q && (((thr_q != 8'd0) && (32'(level_q) >= 32'(thr_q)))
                             || ovr_q || fr_q || pe);
    end
  end
  assign IRQ = irq_q;

  // ---------------- AXI read channel ----------------
  r_state_e r_state_q, r_state_d;
  logic [31:0] rdata_q, rd_mux, stat_word;
  logic        ar_hs;

  assign stat_word = {8'b0, thr_q, 5'b0, par_odd, par_en, intr_en_q, 3'b0,
                      full, pe, fr_q, ovr_q, !empty};
  assign ar_hs = S_AXI_ARVALID && (r_state_q == R_IDLE);
  assign pop   = ar_hs && (S_AXI_ARADDR == A_RXD) && !empty;

  always_comb begin
    case (S_AXI_ARADDR)
      A_DIV:   rd_mux = div_q;
      A_STAT:  rd_mux = stat_word;
      A_RXD:   rd_mux = empty ? '0 : 32'(mem[rd_ptr_q]);
      A_LVL:   rd_mux = 32'(level_q);
      default: rd_mux = '0;
    endcase
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      default: if (S_AXI_RREADY) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) rdata_q <= rd_mux;
    end
  end
  assign S_AXI_ARREADY = (r_state_q == R_IDLE);
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = '0;
endmodule

// File: tb/tb_uart_rx_fifo_axils.sv
// Bench for uart_rx_fifo_axils: register table plus UART frame sequences with a byte scoreboard.
module tb_uart_rx_fifo_axils;
  logic        clk = 1'b0, rst;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready, uart_rx;
  logic [31:0] wdata;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  uart_rx_fifo_axils dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .UART_RX(uart_rx), .IRQ(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake timed out, expected completion within 50 cycles", name);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
    int  t;
    bit  ha, hw;
    @(posedge clk); #1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    while ((awvalid || wvalid) && t < 50) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(posedge clk); #1;
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
      t++;
    end
    if (awvalid || wvalid) begin
      timeout("aw_w");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(posedge clk); #1; t++; end
    if (!bvalid) timeout("bvalid");
    else check("bresp", {30'b0, bresp}, 32'h0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int t;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    t = 0;
    while (!rvalid && t < 50) begin @(posedge clk); #1; t++; end
    d = rdata;
    if (!rvalid) timeout("rvalid");
    else check("rresp", {30'b0, rresp}, 32'h0);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    axi_read(a, d);
    check(name, d, exp);
  endtask

  task automatic rd_pop(input string name);
    logic [31:0] d;
    axi_read(4'h8, d);
    if (exp_q.size() == 0) timeout({name, "_sb_underflow"});
    else check(name, d, {24'b0, exp_q.pop_front()});
  endtask

  task automatic uart_send(input logic [7:0] b, input int div, input bit par_on,
                           input bit pbit, input bit stop);
    uart_rx = 1'b0;
    repeat (div) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (div) @(posedge clk);
    end
    if (par_on) begin
      uart_rx = pbit;
      repeat (div) @(posedge clk);
    end
    uart_rx = stop;
    repeat (div) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * div) @(posedge clk);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; uart_rx = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("rst_awready", {31'b0, awready}, 32'd1);
    check("rst_wready",  {31'b0, wready},  32'd1);
    check("rst_arready", {31'b0, arready}, 32'd1);
    check("rst_bvalid",  {31'b0, bvalid},  32'd0);
    check("rst_rvalid",  {31'b0, rvalid},  32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_irq",     {31'b0, irq},     32'd0);
    rst = 1'b0;

    // Register map table: writes apply data, reads compare against data.
    tbl.push_back('{1'b0, 4'h0, 32'd10416, "div_rst"});
    tbl.push_back('{1'b0, 4'h4, 32'h0,     "stat_rst"});
    tbl.push_back('{1'b0, 4'hC, 32'h0,     "level_rst"});
    tbl.push_back('{1'b0, 4'h8, 32'h0,     "rxdata_empty"});
    tbl.push_back('{1'b1, 4'h0, 32'd2,     "w_div_small"});
    tbl.push_back('{1'b0, 4'h0, 32'd4,     "div_clamp"});
    tbl.push_back('{1'b1, 4'h0, 32'd868,   "w_div"});
    tbl.push_back('{1'b0, 4'h0, 32'd868,   "div_868"});
    tbl.push_back('{1'b1, 4'h4, 32'h0003_0700, "w_ctrl"});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{1'b0, 4'h4, 32'h0003_0700, "ctrl_rb"});
`else
    tbl.push_back('{1'b0, 4'h4, 32'h0003_0100, "ctrl_rb"});
`endif
    tbl.push_back('{1'b1, 4'h4, 32'h0,     "w_ctrl_clr"});
    tbl.push_back('{1'b0, 4'h4, 32'h0,     "ctrl_clr_rb"});
    tbl.push_back('{1'b1, 4'hC, 32'd5,     "w_level_ro"});
    tbl.push_back('{1'b0, 4'hC, 32'h0,     "level_ro"});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data);
      else           rd_chk(tbl[i].addr, tbl[i].data, tbl[i].name);
    end

    // Single 8N1 frame at DIV=868
    exp_q.push_back(8'hA5);
    uart_send(8'hA5, 868, 1'b0, 1'b0, 1'b1);
    rd_chk(4'h4, 32'h1, "a5_stat");
    rd_chk(4'hC, 32'd1, "a5_level");
    rd_pop("a5_rxdata");
    rd_chk(4'hC, 32'd0, "a5_level_after");
    rd_chk(4'h4, 32'h0, "a5_stat_after");

    // Fill past capacity at DIV=16
    axi_write(4'h0, 32'd16);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      uart_send(8'(i), 16, 1'b0, 1'b0, 1'b1);
    end
    rd_chk(4'hC, 32'd16, "full_level");
    rd_chk(4'h4, 32'h13, "full_stat");
    for (int i = 0; i < 16; i++) rd_pop("full_rxdata");
    rd_chk(4'h4, 32'h2, "ovr_sticky");
    axi_write(4'h4, 32'h2);
    rd_chk(4'h4, 32'h0, "ovr_w1c");

    // Frame error
    uart_send(8'h3C, 16, 1'b0, 1'b0, 1'b0);
    rd_chk(4'h4, 32'h4, "ferr_stat");
    rd_chk(4'hC, 32'd0, "ferr_level");
    axi_write(4'h4, 32'h4);
    rd_chk(4'h4, 32'h0, "ferr_w1c");

`ifdef UART_RX_PARITY_EN
    axi_write(4'h4, 32'h200);
    uart_send(8'h07, 16, 1'b1, 1'b0, 1'b1);
    rd_chk(4'h4, 32'h208, "perr_stat");
    rd_chk(4'hC, 32'd0, "perr_level");
    axi_write(4'h4, 32'h208);
    rd_chk(4'h4, 32'h200, "perr_w1c");
    exp_q.push_back(8'h07);
    uart_send(8'h07, 16, 1'b1, 1'b1, 1'b1);
    rd_chk(4'hC, 32'd1, "par_ok_level");
    rd_pop("par_ok_rxdata");
    axi_write(4'h4, 32'h0);
`else
    axi_write(4'h4, 32'h60E);
    rd_chk(4'h4, 32'h0, "nopar_bits");
`endif

    // Threshold interrupt
    axi_write(4'h4, 32'h0003_0100);
    exp_q.push_back(8'h11); uart_send(8'h11, 16, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'h22); uart_send(8'h22, 16, 1'b0, 1'b0, 1'b1);
    check("irq_two", {31'b0, irq}, 32'd0);
    exp_q.push_back(8'h33); uart_send(8'h33, 16, 1'b0, 1'b0, 1'b1);
    check("irq_three", {31'b0, irq}, 32'd1);
    rd_pop("irq_rxdata");
    repeat (3) @(posedge clk); #1;
    check("irq_after_pop", {31'b0, irq}, 32'd0);
    rd_pop("irq_drain");
    rd_pop("irq_drain");
    axi_write(4'h4, 32'h0);

    // Reset in the middle of a frame, line held low through release
    uart_rx = 1'b0;
    repeat (16) @(posedge clk);
    uart_rx = 1'b1; repeat (16) @(posedge clk);
    uart_rx = 1'b0; repeat (16) @(posedge clk);
    #1; rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (20) @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (64) @(posedge clk); #1;
    rd_chk(4'h0, 32'd10416, "div_after_rst");
    axi_write(4'h0, 32'd16);
    exp_q.push_back(8'h55);
    uart_send(8'h55, 16, 1'b0, 1'b0, 1'b1);
    rd_chk(4'hC, 32'd1, "rst_mid_level");
    rd_chk(4'h4, 32'h1, "rst_mid_stat");
    rd_pop("rst_mid_rxdata");
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
